// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two SRAM requesters (CPU, DMA), the SRAM macro and
// the sram_port_arbiter.
//
// Signal groups:
//   cpu_*          CPU request fields in, cpu_gnt / cpu_rvalid back
//   dma_*          DMA request fields in, dma_gnt / dma_rvalid back
//   rdata          shared read data returned to whichever requester has rvalid
//   sram_*         SRAM control/data out, sram_DO from the SRAM
//   *_grant_cnt    saturating grant statistics
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters + SRAM)
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] sram_ADDR;
  logic [DATA_W-1:0] sram_DI;
  logic              sram_EN;
  logic              sram_WE;
  logic [DATA_W-1:0] sram_DO;

  logic [CNT_W-1:0]  cpu_grant_cnt;
  logic [CNT_W-1:0]  dma_grant_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  sram_DO,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    output sram_ADDR, sram_DI, sram_EN, sram_WE,
    output cpu_grant_cnt, dma_grant_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output sram_DO,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    input  sram_ADDR, sram_DI, sram_EN, sram_WE,
    input  cpu_grant_cnt, dma_grant_cnt
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between the CPU control
// path (requester 0) and the DMA copy engine (requester 1).
//
// Each cycle at most one access is selected and the SRAM control signals are
// driven combinationally from the winner. Read data comes back from the SRAM
// one cycle after the grant and is flagged with the rvalid of the requester
// that issued the read. The CPU has fixed priority; a starvation counter lets
// the DMA win a contested cycle after STARVE_LIMIT consecutive denials.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    sram_port_arbiter_if.slave: requester handshakes, SRAM drive,
//          shared rdata and grant statistics counters
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,  // legal range 1..15
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_port_arbiter_if.slave    bus
);

  localparam logic [3:0]       StarveLimit = 4'(STARVE_LIMIT);
  localparam logic [3:0]       StarveMax   = 4'hF;
  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};

  logic             cpu_win;
  logic             dma_win;
  logic             rd_grant;

  logic [3:0]       starve_q, starve_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q, rd_owner_d;   // 0 = cpu, 1 = dma
  logic [CNT_W-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;

  // Arbitration. Reset suppresses every grant so nothing reaches the SRAM.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!reset) begin
      if (bus.dma_req && (!bus.cpu_req || (starve_q >= StarveLimit))) begin
        dma_win = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_win = 1'b1;
      end
    end
  end

  // SRAM drive. Idle cycles present all-zero controls; write data is only
  // forwarded on writes so DI stays quiet during reads.
  always_comb begin
    bus.sram_EN   = 1'b0;
    bus.sram_WE   = 1'b0;
    bus.sram_ADDR = '0;
    bus.sram_DI   = '0;
    if (dma_win) begin
      bus.sram_EN   = 1'b1;
      bus.sram_WE   = bus.dma_we;
      bus.sram_ADDR = bus.dma_addr;
      bus.sram_DI   = bus.dma_we ? bus.dma_wdata : '0;
    end else if (cpu_win) begin
      bus.sram_EN   = 1'b1;
      bus.sram_WE   = bus.cpu_we;
      bus.sram_ADDR = bus.cpu_addr;
      bus.sram_DI   = bus.cpu_we ? bus.cpu_wdata : '0;
    end
  end

  assign rd_grant = (cpu_win && !bus.cpu_we) || (dma_win && !bus.dma_we);

  // Next-state logic.
  always_comb begin
    // Starvation: count denied DMA cycles, clear on grant or when DMA is idle.
    starve_d = '0;
    if (bus.dma_req && !dma_win) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end

    // One-deep read return pipeline; a new read may be granted while the
    // previous one is being returned.
    rd_pending_d = rd_grant;
    rd_owner_d   = rd_grant ? dma_win : rd_owner_q;

    cpu_cnt_d = cpu_cnt_q;
    if (cpu_win && (cpu_cnt_q != CntMax)) begin
      cpu_cnt_d = cpu_cnt_q + 1'b1;
    end

    dma_cnt_d = dma_cnt_q;
    if (dma_win && (dma_cnt_q != CntMax)) begin
      dma_cnt_d = dma_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      cpu_cnt_q    <= '0;
      dma_cnt_q    <= '0;
    end else begin
      starve_q     <= starve_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      cpu_cnt_q    <= cpu_cnt_d;
      dma_cnt_q    <= dma_cnt_d;
    end
  end

  assign bus.cpu_gnt = cpu_win;
  assign bus.dma_gnt = dma_win;

  // rvalid is masked by reset so a read in flight when reset arrives is
  // dropped immediately rather than surfacing for one more cycle.
  assign bus.cpu_rvalid = rd_pending_q && !rd_owner_q && !reset;
  assign bus.dma_rvalid = rd_pending_q &&  rd_owner_q && !reset;

  assign bus.rdata = bus.sram_DO;

  assign bus.cpu_grant_cnt = cpu_cnt_q;
  assign bus.dma_grant_cnt = dma_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 time
// units after the rising edge.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  sram_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(4),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write commits at the edge of the grant, read data appears the
  // cycle after the read enable. Preloaded contents are restored on reset.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h100] <= 32'h11111111;
      mem[10'h005] <= 32'h55555555;
      mem[10'h006] <= 32'h66666666;
      bus.sram_DO  <= '0;
    end else if (bus.sram_EN) begin
      if (bus.sram_WE) mem[bus.sram_ADDR[9:0]] <= bus.sram_DI;
      else bus.sram_DO <= mem[bus.sram_ADDR[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();
    cpu(1'b0, 16'h0010, '0);

    // Reset: request present but nothing may be granted or driven.
    next(); #1;
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_sram_en", bus.sram_EN, 0);
    chk("rst_sram_addr", bus.sram_ADDR, 0);
    next(); #1;
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rst_cpu_cnt", bus.cpu_grant_cnt, 0);
    chk("rst_dma_cnt", bus.dma_grant_cnt, 0);
    reset = 1'b0;
    idle();
    #1;
    chk("idle_sram_en", bus.sram_EN, 0);

    // CPU read only.
    next(); cpu(1'b0, 16'h0010, '0); #1;
    chk("rd_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd_dma_gnt", bus.dma_gnt, 0);
    chk("rd_sram_en", bus.sram_EN, 1);
    chk("rd_sram_we", bus.sram_WE, 0);
    chk("rd_sram_addr", bus.sram_ADDR, 32'h0010);
    chk("rd_sram_di", bus.sram_DI, 0);
    next(); idle(); #1;
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
    chk("rd_dma_rvalid", bus.dma_rvalid, 0);
    chk("rd_cpu_cnt", bus.cpu_grant_cnt, 1);
    next(); #1;
    chk("rd_cpu_rvalid_drop", bus.cpu_rvalid, 0);

    // Contention: CPU wins cycles 0-3, DMA wins cycle 4, CPU again in 5.
    next();
    cpu(1'b1, 16'h0030, 32'hAAAA0030);
    dma(1'b1, 16'h0031, 32'hBBBB0031);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("cont_cpu_gnt_c%0d", c), bus.cpu_gnt, (c != 4) ? 1 : 0);
      chk($sformatf("cont_dma_gnt_c%0d", c), bus.dma_gnt, (c == 4) ? 1 : 0);
      if (c == 4) begin
        chk("cont_starve_c4", dut.starve_q, 4);
        chk("cont_di_c4", bus.sram_DI, 32'hBBBB0031);
      end
      if (c == 5) chk("cont_starve_c5", dut.starve_q, 0);
      next();
    end
    idle(); #1;
    chk("cont_cpu_cnt", bus.cpu_grant_cnt, 6);
    chk("cont_dma_cnt", bus.dma_grant_cnt, 1);
    chk("cont_mem_30", mem[10'h030], 32'hAAAA0030);
    chk("cont_mem_31", mem[10'h031], 32'hBBBB0031);

    // DMA copy: read 0x0100 then write 0x0200.
    next(); dma(1'b0, 16'h0100, '0); #1;
    chk("copy_dma_gnt", bus.dma_gnt, 1);
    chk("copy_cpu_gnt", bus.cpu_gnt, 0);
    chk("copy_rd_addr", bus.sram_ADDR, 32'h0100);
    next(); dma(1'b1, 16'h0200, 32'h11111111); #1;
    chk("copy_dma_rvalid", bus.dma_rvalid, 1);
    chk("copy_rdata", bus.rdata, 32'h11111111);
    chk("copy_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("copy_wr_gnt", bus.dma_gnt, 1);
    chk("copy_wr_we", bus.sram_WE, 1);
    chk("copy_wr_di", bus.sram_DI, 32'h11111111);
    next(); idle(); #1;
    chk("copy_wr_no_rvalid", bus.dma_rvalid, 0);
    chk("copy_mem_200", mem[10'h200], 32'h11111111);
    chk("copy_dma_cnt", bus.dma_grant_cnt, 3);

    // Back-to-back mixed reads.
    next(); cpu(1'b0, 16'h0005, '0); #1;
    chk("b2b_cpu_gnt", bus.cpu_gnt, 1);
    next(); idle(); dma(1'b0, 16'h0006, '0); #1;
    chk("b2b_dma_gnt", bus.dma_gnt, 1);
    chk("b2b_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("b2b_dma_rvalid0", bus.dma_rvalid, 0);
    chk("b2b_rdata5", bus.rdata, 32'h55555555);
    next(); idle(); #1;
    chk("b2b_dma_rvalid", bus.dma_rvalid, 1);
    chk("b2b_cpu_rvalid0", bus.cpu_rvalid, 0);
    chk("b2b_rdata6", bus.rdata, 32'h66666666);
    chk("b2b_cpu_cnt", bus.cpu_grant_cnt, 7);
    chk("b2b_dma_cnt", bus.dma_grant_cnt, 4);

    // Write then read of the same address returns the new data.
    next(); cpu(1'b1, 16'h0040, 32'hCAFEF00D); #1;
    chk("wr_rd_wgnt", bus.cpu_gnt, 1);
    next(); cpu(1'b0, 16'h0040, '0); #1;
    chk("wr_rd_no_rvalid", bus.cpu_rvalid, 0);
    next(); idle(); #1;
    chk("wr_rd_rvalid", bus.cpu_rvalid, 1);
    chk("wr_rd_rdata", bus.rdata, 32'hCAFEF00D);
    chk("wr_rd_cpu_cnt", bus.cpu_grant_cnt, 9);

    // Reset mid-read: the pending rvalid is dropped.
    next(); cpu(1'b0, 16'h0010, '0); #1;
    chk("rmr_gnt", bus.cpu_gnt, 1);
    next(); reset = 1'b1; cpu(1'b0, 16'h0077, '0); #1;
    chk("rmr_c1_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rmr_c1_dma_rvalid", bus.dma_rvalid, 0);
    chk("rmr_c1_gnt", bus.cpu_gnt, 0);
    chk("rmr_c1_en", bus.sram_EN, 0);
    chk("rmr_c1_we", bus.sram_WE, 0);
    chk("rmr_c1_addr", bus.sram_ADDR, 0);
    chk("rmr_c1_di", bus.sram_DI, 0);
    next(); reset = 1'b0; idle(); #1;
    chk("rmr_c2_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rmr_c2_dma_rvalid", bus.dma_rvalid, 0);
    chk("rmr_c2_cpu_cnt", bus.cpu_grant_cnt, 0);
    chk("rmr_c2_dma_cnt", bus.dma_grant_cnt, 0);
    chk("rmr_c2_en", bus.sram_EN, 0);

    // Counter saturation at 2^4-1 with 20 consecutive CPU grants.
    next(); cpu(1'b1, 16'h0050, 32'h00000050);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("sat_gnt_%0d", i), bus.cpu_gnt, 1);
      if (i == 14) chk("sat_cnt_14", bus.cpu_grant_cnt, 14);
      next();
    end
    idle(); #1;
    chk("sat_cpu_cnt", bus.cpu_grant_cnt, 15);
    chk("sat_dma_cnt", bus.dma_grant_cnt, 0);
    next(); #1;
    chk("sat_cpu_cnt_hold", bus.cpu_grant_cnt, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single-port synchronous SRAM between the CPU control path (requester 0) and the DMA copy engine (requester 1). Each cycle it selects at most one access and drives the SRAM control signals combinationally. It returns read data one cycle later to the requester that issued the read. The CPU has fixed priority, and a starvation counter guarantees the DMA forward progress.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 32, SRAM data width
STARVE_LIMIT, 4, consecutive denied DMA request cycles after which the DMA wins the next contested cycle (legal range 1..15)
CNT_W, 16, width of the saturating grant statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held high with stable fields until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU access address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  combinational; CPU access issued to SRAM this cycle
cpu_rvalid  out  1  registered; CPU read data valid this cycle
dma_req  in  1  DMA access request; same hold rule as cpu_req
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA access address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  combinational; DMA access issued to SRAM this cycle
dma_rvalid  out  1  registered; DMA read data valid this cycle
rdata  out  DATA_W  shared read data; direct pass-through of sram_DO
sram_ADDR  out  ADDR_W  to SRAM
sram_DI  out  DATA_W  to SRAM
sram_EN  out  1  to SRAM
sram_WE  out  1  to SRAM
sram_DO  in  DATA_W  from SRAM; valid the cycle after a read enable
cpu_grant_cnt  out  CNT_W  saturating count of CPU grants
dma_grant_cnt  out  CNT_W  saturating count of DMA grants

Behaviour:
- Reset (sync, active-high): starve_cnt=0, rd_pending=0, rd_owner=0, both rvalid=0, both grant counters=0.
  - While reset is high, cpu_gnt, dma_gnt, sram_EN and sram_WE are forced to 0.
  - Reset mid-read drops the pending rvalid; no rvalid appears in the following cycle.
- Arbitration (combinational, every cycle):
  - Only cpu_req high: cpu wins.
  - Only dma_req high: dma wins.
  - Both high: dma wins if starve_cnt >= STARVE_LIMIT, otherwise cpu wins.
  - Neither high: no winner.
  - Exactly one gnt is high when any request is high; never both.
- SRAM drive:
  - With a winner: sram_EN=1, sram_WE=winner_we, sram_ADDR=winner_addr, sram_DI = winner_wdata if writing, else 0.
  - With no winner: ADDR, DI, EN and WE are all 0.
- Starvation counter: 4-bit register.
  - Increments (saturating at 15) when dma_req=1 and dma_gnt=0.
  - Clears to 0 on dma_gnt=1 or when dma_req=0.
- Read return:
  - A granted read sets rd_pending=1 next cycle and stores the winner in rd_owner (0 = cpu, 1 = dma).
  - During that cycle the matching rvalid is 1 and rdata=sram_DO.
  - Latency from gnt to rvalid is exactly 1 cycle.
- Write return: a granted write produces no rvalid.
- Back-to-back reads:
  - Reads may be granted every cycle.
  - A new grant in the same cycle as an rvalid is legal; the SRAM read pipeline is one deep and non-blocking.
- Write followed by read to the same address: the read returns the new data, as the SRAM commits the write at the clock edge of the write grant.
- Statistics counters: each counter increments by 1 on its gnt and holds at 2^CNT_W-1 (no wrap).
- Requester contract: a requester must hold req and its fields until gnt is seen, and must drop or change them the cycle after gnt. The arbiter does not check this.

Test Plan:
- CPU read only: cpu_req=1, we=0, addr=0x0010, SRAM[0x10]=0xDEADBEEF -> cpu_gnt=1 and sram_EN=1, ADDR=0x0010 in cycle 0; cpu_rvalid=1 and rdata=0xDEADBEEF in cycle 1; dma_rvalid stays 0.
- Contention and starvation (STARVE_LIMIT=4): cpu_req and dma_req both held high -> cpu_gnt in cycles 0-3, dma_gnt in cycle 4, starve_cnt=0 in cycle 5, cpu_gnt again in cycle 5.
- DMA copy interleave: DMA reads 0x0100 (0x11111111) then writes 0x0200 while the CPU is idle -> dma_rvalid one cycle after the read gnt with rdata=0x11111111; SRAM[0x0200]=0x11111111 after the write gnt; no cpu_rvalid.
- Back-to-back mixed reads: CPU read 0x5 in cycle 0, DMA read 0x6 in cycle 1 -> cpu_rvalid in cycle 1 with SRAM[5]; dma_rvalid in cycle 2 with SRAM[6]; never both rvalids high together.
- Reset mid-read: read granted in cycle 0, reset asserted in cycle 1 -> both rvalids 0 in cycles 1-2, grant counters 0, SRAM outputs 0.
- Counter saturation (CNT_W=4): 20 consecutive CPU grants -> cpu_grant_cnt=15 and holding; dma_grant_cnt=0.
